// File: rtl/defines_package.sv
// defines_package: shared definitions for the z-buffer responder.
//   ADDR_W_DEF / DATA_W_DEF : default pixel address and z/colour data widths
//   WIDTH / HEIGHT          : frame geometry (address = row*WIDTH + col)
//   zbuf_state_e            : responder FSM state encoding
package defines_package;

  localparam int WIDTH      = 640;
  localparam int HEIGHT     = 480;
  // Address width is derived from the frame size so it always covers it.
  localparam int ADDR_W_DEF = $clog2(WIDTH * HEIGHT);
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } zbuf_state_e;

endpackage

// File: rtl/zbuf_wfifo.sv
// zbuf_wfifo: posted-write queue for the z-buffer responder.
//   clk, rst              : clock, synchronous active-high reset
//   push, push_addr/data  : enqueue one write (caller guarantees not full)
//   pop                   : drop the head entry (caller guarantees not empty)
//   count                 : registered occupancy, 0..DEPTH
//   head_addr/head_data   : oldest entry, presented to the SRAM on drain
//   look_addr, hit,       : forwarding lookup against the registered contents;
//   hit_data                the youngest matching entry wins. Built only when
//                           ZBUF_FWD_EN is defined, otherwise hit is tied low.
module zbuf_wfifo
  import defines_package::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  input  logic [ADDR_W-1:0]          look_addr,
  output logic                       hit,
  output logic [DATA_W-1:0]          hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Pointers are PTR_W bits wide, so DEPTH being a power of two makes them
  // wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= push_addr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

`ifdef ZBUF_FWD_EN
  logic [PTR_W-1:0] idx;

  // Walk entries oldest to youngest; a later match overrides an earlier one.
  // Only registered contents are searched, so an entry pushed this cycle is
  // invisible to a read accepted in the same cycle.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_mem[idx] == look_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end
`else
  logic [ADDR_W-1:0] unused_look;
  assign unused_look = look_addr;
  assign hit         = 1'b0;
  assign hit_data    = '0;
`endif

endmodule

// File: rtl/zbuf_responder.sv
// zbuf_responder: z-buffer read/write responder in front of a variable-latency
// SRAM. Writes are posted into a small queue and drained in the background;
// reads go to the SRAM, or are answered from the queue when ZBUF_FWD_EN is
// defined. Without ZBUF_FWD_EN reads stall until the queue is empty.
//   clk, rst                  : clock, synchronous active-high reset
//   rd_en/rd_addr, rd_busy    : read request; accepted when rd_en && !rd_busy
//   rd_valid/rd_data          : one-cycle read return; rd_data holds otherwise
//   wr_en/wr_addr/wr_data,    : write request; accepted when wr_en && !wr_full
//   wr_full
//   idle                      : nothing queued, no read in flight, FSM in IDLE
//   mem_req/mem_we/mem_addr/  : SRAM request, held until mem_ack
//   mem_wdata, mem_ack,
//   mem_rdata
//   dbg_state                 : current FSM state
// Handshakes: a request is taken on a rising edge where its enable is high and
// the matching busy/full flag is low; busy/full never depend on the enables.
// The SRAM side holds mem_req and its payload stable until the edge where
// mem_ack is seen; mem_ack in IDLE is ignored.
module zbuf_responder
  import defines_package::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic              idle,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output zbuf_state_e       dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  zbuf_state_e       state, state_next;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              rd_accept, wr_accept, pop;

  logic              mem_req_d, mem_we_d, rd_valid_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, rd_data_d;

  zbuf_wfifo #(
    .DEPTH (FIFO_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wfifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_accept),
    .push_addr(wr_addr),
    .push_data(wr_data),
    .pop      (pop),
    .count    (count),
    .head_addr(head_addr),
    .head_data(head_data),
    .look_addr(rd_addr),
    .hit      (hit),
    .hit_data (hit_data)
  );

  // Full comes from the registered count: a pop this cycle frees a slot only
  // from the next cycle on.
  assign wr_full = (count == CNT_W'(FIFO_DEPTH));

  // A read is refused while one is being returned (rd_valid high) so at most
  // one read is ever in flight.
`ifdef ZBUF_FWD_EN
  assign rd_busy = (state != ST_IDLE) || wr_full || rd_valid;
`else
  // No forwarding: a read may only go to the SRAM once every queued write has
  // landed there, which keeps read-after-write coherent.
  assign rd_busy = (state != ST_IDLE) || wr_full || rd_valid || (count != '0);
`endif

  assign rd_accept = rd_en && !rd_busy;
  assign wr_accept = wr_en && !wr_full;
  assign pop       = (state == ST_WR_WAIT) && mem_ack;
  assign idle      = (state == ST_IDLE) && (count == '0) && !rd_valid;
  assign dbg_state = state;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_next;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
    end
  end

  // Next state. A full queue forces a drain (rd_busy is high then, so no read
  // can be accepted); otherwise an accepted read wins over draining.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (wr_full)          state_next = ST_WR_WAIT;
        else if (rd_accept)   state_next = hit ? ST_IDLE : ST_RD_WAIT;
        else if (count != '0) state_next = ST_WR_WAIT;
      end
      ST_RD_WAIT: if (mem_ack) state_next = ST_IDLE;
      ST_WR_WAIT: if (mem_ack) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs. The SRAM payload is loaded only on
  // leaving IDLE, which keeps it stable for the whole wait.
  always_comb begin
    mem_req_d   = (state_next != ST_IDLE);
    mem_we_d    = (state_next == ST_WR_WAIT);
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data;
    if (state == ST_IDLE && state_next == ST_RD_WAIT) begin
      mem_addr_d = rd_addr;
    end
    if (state == ST_IDLE && state_next == ST_WR_WAIT) begin
      mem_addr_d  = head_addr;
      mem_wdata_d = head_data;
    end
    if (rd_accept && hit) begin
      rd_valid_d = 1'b1;
      rd_data_d  = hit_data;
    end
    if (state == ST_RD_WAIT && mem_ack) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_rdata;
    end
  end

endmodule
